// File: rtl/spi_slave_if.sv
// SPI pin bundle between the ESP32 master and the fabric slave.
// Mode 0: sclk idles low, cs is active low, data moves MSB first.
interface spi_slave_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport slave  (input sclk, input cs, input mosi, output miso);
  modport master (output sclk, output cs, output mosi, input miso);
endinterface

// File: rtl/spi_slave.sv
// SPI Mode 0 slave, oversampled in sysclk. It decodes cmd/addr/payload frames
// into one-cycle register write strobes, or serves register reads on miso.
module spi_slave #(
  parameter int               CMD_W     = 8,
  parameter int               ADDR_W    = 8,
  parameter int               DATA_W    = 8,
  parameter logic [CMD_W-1:0] CMD_WRITE = 8'h02,
  parameter logic [CMD_W-1:0] CMD_READ  = 8'h03
) (
  input  logic              sysclk,
  input  logic              rst_n,
  spi_slave_if.slave        spi,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_wr_en,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_busy,
  output logic              o_frame_err,
  output logic              o_cmd_err
);

  localparam int MAX_W = (CMD_W > ADDR_W) ? ((CMD_W > DATA_W) ? CMD_W : DATA_W)
                                          : ((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  logic r_sclk_p0, r_sclk_p1, r_sclk_p2;
  logic r_cs_p0, r_cs_p1, r_cs_p2;
  logic r_mosi_p0, r_mosi_p1;

  // Stage p0/p1: two-flop synchronizers; p2: previous sample for edge detect.
  // cs syncs reset to the asserted level so a frame already under way at
  // reset release never produces a falling edge and is ignored.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_p0 <= 1'b0;
      r_sclk_p1 <= 1'b0;
      r_sclk_p2 <= 1'b0;
      r_cs_p0   <= 1'b0;
      r_cs_p1   <= 1'b0;
      r_cs_p2   <= 1'b0;
      r_mosi_p0 <= 1'b0;
      r_mosi_p1 <= 1'b0;
    end else begin
      r_sclk_p0 <= spi.sclk;
      r_sclk_p1 <= r_sclk_p0;
      r_sclk_p2 <= r_sclk_p1;
      r_cs_p0   <= spi.cs;
      r_cs_p1   <= r_cs_p0;
      r_cs_p2   <= r_cs_p1;
      r_mosi_p0 <= spi.mosi;
      r_mosi_p1 <= r_mosi_p0;
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_high, w_mosi;
  assign w_sclk_rise = r_sclk_p1 & ~r_sclk_p2;
  assign w_sclk_fall = ~r_sclk_p1 & r_sclk_p2;
  assign w_cs_fall   = ~r_cs_p1 & r_cs_p2;
  assign w_cs_high   = r_cs_p1;
  assign w_mosi      = r_mosi_p1;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CMD_W-1:0]  r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_tx;
  logic              r_rd_arm, r_rd_act;
  logic              r_miso, r_wr_en, r_busy, r_frame_err, r_cmd_err;

  logic w_cmd_last, w_addr_last, w_data_last;
  assign w_cmd_last  = (r_cnt == CNT_W'(CMD_W - 1));
  assign w_addr_last = (r_cnt == CNT_W'(ADDR_W - 1));
  assign w_data_last = (r_cnt == CNT_W'(DATA_W - 1));

  // Frame FSM: all outputs registered, strobes default low every cycle.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_tx        <= '0;
      r_rd_arm    <= 1'b0;
      r_rd_act    <= 1'b0;
      r_miso      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_busy      <= ~r_cs_p1;
      case (r_state)
        S_IDLE: begin
          r_miso <= 1'b0;
          if (w_cs_fall) begin
            r_state <= S_CMD;
            r_cnt   <= '0;
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          if (w_cs_high) begin
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
            r_miso      <= 1'b0;
            r_rd_arm    <= 1'b0;
            r_rd_act    <= 1'b0;
          end else if (r_state == S_CMD) begin
            if (w_sclk_rise) begin
              r_cmd <= {r_cmd[CMD_W-2:0], w_mosi};
              r_cnt <= r_cnt + 1'b1;
              if (w_cmd_last) begin
                r_state <= S_ADDR;
                r_cnt   <= '0;
              end
            end
          end else if (r_state == S_ADDR) begin
            if (w_sclk_rise) begin
              r_addr <= {r_addr[ADDR_W-2:0], w_mosi};
              r_cnt  <= r_cnt + 1'b1;
              if (w_addr_last) begin
                r_state  <= S_DATA;
                r_cnt    <= '0;
                r_rd_arm <= (r_cmd == CMD_READ);
              end
            end
          end else begin
            // First fall in DATA loads the bank word; later falls shift it out.
            if (w_sclk_fall) begin
              if (r_rd_arm) begin
                r_tx     <= i_rdata;
                r_miso   <= i_rdata[DATA_W-1];
                r_rd_arm <= 1'b0;
                r_rd_act <= 1'b1;
              end else if (r_rd_act) begin
                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                r_miso <= r_tx[DATA_W-2];
              end
            end
            if (w_sclk_rise) begin
              r_wdata <= {r_wdata[DATA_W-2:0], w_mosi};
              r_cnt   <= r_cnt + 1'b1;
              if (w_data_last) begin
                r_state  <= S_DONE;
                r_miso   <= 1'b0;
                r_rd_arm <= 1'b0;
                r_rd_act <= 1'b0;
                if (r_cmd == CMD_WRITE)
                  r_wr_en <= 1'b1;
                else if (r_cmd != CMD_READ)
                  r_cmd_err <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          r_miso <= 1'b0;
          if (w_cs_high)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spi.miso    = r_miso;
  assign o_addr      = r_addr;
  assign o_wdata     = r_wdata;
  assign o_wr_en     = r_wr_en;
  assign o_busy      = r_busy;
  assign o_frame_err = r_frame_err;
  assign o_cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a table of whole frames plus hand-written
// reset-mid-frame and back-to-back sequences, against a tiny register bank.
module tb_spi_slave;
  localparam int HP = 6;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] o_addr, i_rdata, o_wdata;
  logic       o_wr_en, o_busy, o_frame_err, o_cmd_err;

  spi_slave_if spi_if ();

  spi_slave dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .spi         (spi_if.slave),
    .o_addr      (o_addr),
    .i_rdata     (i_rdata),
    .o_wr_en     (o_wr_en),
    .o_wdata     (o_wdata),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err),
    .o_cmd_err   (o_cmd_err)
  );

  always #5 sysclk = ~sysclk;

  // Register bank read port: address 0x05 returns 0xA5.
  assign i_rdata = o_addr ^ 8'hA0;

  int         wr_cnt = 0, ferr_cnt = 0, cerr_cnt = 0, miso_hi_cnt = 0;
  logic [7:0] wr_addr_log[$];
  logic [7:0] wr_data_log[$];

  always @(negedge sysclk) begin
    if (o_wr_en) begin
      wr_cnt++;
      wr_addr_log.push_back(o_addr);
      wr_data_log.push_back(o_wdata);
    end
    if (o_frame_err) ferr_cnt++;
    if (o_cmd_err)   cerr_cnt++;
    if (spi_if.miso) miso_hi_cnt++;
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic sclk_bit(input logic b, output logic s);
    spi_if.mosi = b;
    wait_cyc(HP);
    spi_if.sclk = 1'b1;
    s = spi_if.miso;
    wait_cyc(HP);
    spi_if.sclk = 1'b0;
  endtask

  // Drives nbits of v (MSB first), then `extra` pulses with mosi high, and
  // returns the last 8 miso bits sampled on rising sclk.
  task automatic frame(input logic [23:0] v, input int nbits, input int extra,
                       input int cs_tail, output logic [7:0] rx);
    logic s;
    rx = '0;
    spi_if.cs = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < nbits; i++) begin
      sclk_bit(v[23-i], s);
      rx = {rx[6:0], s};
    end
    for (int i = 0; i < extra; i++) sclk_bit(1'b1, s);
    spi_if.mosi = 1'b0;
    wait_cyc(4);
    spi_if.cs = 1'b1;
    wait_cyc(cs_tail);
  endtask

  typedef struct {
    logic [23:0] bits;
    int          nbits;
    int          extra;
    int          exp_wr;
    int          exp_ferr;
    int          exp_cerr;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_wdata;
    bit          is_read;
    logic [7:0]  exp_rx;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] rx;
    logic       s;
    int         wr0, fe0, ce0, mh0;
    logic [23:0] rv;

    vecs[0] = '{24'h02057F, 24, 0,  1, 0, 0, 8'h05, 8'h7F, 1'b0, 8'h00};
    vecs[1] = '{24'h030500, 24, 0,  0, 0, 0, 8'h05, 8'h00, 1'b1, 8'hA5};
    vecs[2] = '{24'h02057F, 12, 0,  0, 1, 0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[3] = '{24'h02063C, 24, 0,  1, 0, 0, 8'h06, 8'h3C, 1'b0, 8'h00};
    vecs[4] = '{24'h550133, 24, 30, 0, 0, 1, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[5] = '{24'h037E00, 24, 0,  0, 0, 0, 8'h7E, 8'h00, 1'b1, 8'hDE};
    vecs[6] = '{24'h02FF00, 24, 0,  1, 0, 0, 8'hFF, 8'h00, 1'b0, 8'h00};
    vecs[7] = '{24'h0200FF, 24, 0,  1, 0, 0, 8'h00, 8'hFF, 1'b0, 8'h00};

    spi_if.cs   = 1'b1;
    spi_if.sclk = 1'b0;
    spi_if.mosi = 1'b0;
    wait_cyc(4);
    check("rst_outputs", {spi_if.miso, o_addr, o_wr_en, o_wdata, o_busy, o_frame_err, o_cmd_err}, '0);
    rst_n = 1'b1;
    wait_cyc(6);
    check("idle_busy", o_busy, 1'b0);

    for (int i = 0; i < 8; i++) begin
      wr0 = wr_cnt; fe0 = ferr_cnt; ce0 = cerr_cnt; mh0 = miso_hi_cnt;
      frame(vecs[i].bits, vecs[i].nbits, vecs[i].extra, 6, rx);
      check($sformatf("v%0d_wr_cnt", i), wr_cnt - wr0, vecs[i].exp_wr);
      check($sformatf("v%0d_frame_err", i), ferr_cnt - fe0, vecs[i].exp_ferr);
      check($sformatf("v%0d_cmd_err", i), cerr_cnt - ce0, vecs[i].exp_cerr);
      check($sformatf("v%0d_busy_after", i), o_busy, 1'b0);
      if (vecs[i].exp_wr != 0) begin
        check($sformatf("v%0d_wr_addr", i), wr_addr_log[$], vecs[i].exp_addr);
        check($sformatf("v%0d_wr_data", i), wr_data_log[$], vecs[i].exp_wdata);
      end
      if (vecs[i].is_read) check($sformatf("v%0d_rx", i), rx, vecs[i].exp_rx);
      else                 check($sformatf("v%0d_miso_quiet", i), miso_hi_cnt - mh0, 0);
    end

    // Reset in the middle of the address phase.
    wr0 = wr_cnt; fe0 = ferr_cnt; ce0 = cerr_cnt;
    rv = 24'h021001;
    spi_if.cs = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < 12; i++) sclk_bit(rv[23-i], s);
    wait_cyc(4);
    check("midrst_busy_before", o_busy, 1'b1);
    check("midrst_addr_before", o_addr, 8'h01);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {spi_if.miso, o_addr, o_wr_en, o_wdata, o_busy, o_frame_err, o_cmd_err}, '0);
    wait_cyc(3);
    rst_n = 1'b1;
    for (int i = 12; i < 24; i++) sclk_bit(rv[23-i], s);
    wait_cyc(4);
    spi_if.cs = 1'b1;
    wait_cyc(6);
    check("midrst_no_wr", wr_cnt - wr0, 0);
    check("midrst_no_ferr", ferr_cnt - fe0, 0);
    check("midrst_no_cerr", cerr_cnt - ce0, 0);
    check("midrst_addr_held", o_addr, 8'h00);
    wr0 = wr_cnt;
    frame(24'h021001, 24, 0, 6, rx);
    check("postrst_wr_cnt", wr_cnt - wr0, 1);
    check("postrst_addr", wr_addr_log[$], 8'h10);
    check("postrst_data", wr_data_log[$], 8'h01);

    // Back-to-back writes with cs high for only 2 sysclk in between.
    wr0 = wr_cnt; fe0 = ferr_cnt;
    frame(24'h020111, 24, 0, 2, rx);
    frame(24'h020222, 24, 0, 8, rx);
    check("b2b_wr_cnt", wr_cnt - wr0, 2);
    check("b2b_ferr", ferr_cnt - fe0, 0);
    if (wr_cnt - wr0 == 2) begin
      check("b2b_addr0", wr_addr_log[wr_addr_log.size()-2], 8'h01);
      check("b2b_data0", wr_data_log[wr_data_log.size()-2], 8'h11);
      check("b2b_addr1", wr_addr_log[wr_addr_log.size()-1], 8'h02);
      check("b2b_data1", wr_data_log[wr_data_log.size()-1], 8'h22);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
